uart_phy_8n1: RTL
=================

Name: uart_phy_8n1

Overview:
- 8N1 UART physical layer, directly downstream of the UART host-interface handler; it serialises the handler's ASCII bytes onto the line and deserialises line bytes back to it.
- Handshake: one-cycle `transmit` strobe plus `is_transmitting` busy flag on TX; one-cycle `received` strobe with held `rx_byte` on RX.
- Baud timing derives from a free-running oversample tick generator shared by both directions.

Parameters:
- CLOCK_FREQ, 50000000, system clock in Hz.
- BAUD_RATE, 115200, line rate in bit/s.
- OVERSAMPLE, 16, ticks per bit; must be even, >= 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rx  input  1  serial line in, idle high, asynchronous to clk.
- tx  output  1  serial line out, idle high.
- transmit  input  1  one-cycle request to send tx_byte.
- tx_byte  input  8  byte to send, sampled when transmit is accepted.
- received  output  1  one-cycle strobe: rx_byte valid.
- rx_byte  output  8  last received byte, held until next strobe.
- is_receiving  output  1  RX frame in progress.
- is_transmitting  output  1  TX busy.
- recv_error  output  1  one-cycle framing-error strobe (see Optional Feature).

Behaviour:
- Reset values (rst low, asynchronous): tx=1, received=0, rx_byte=0x00, is_receiving=0, is_transmitting=0, recv_error=0; both FSMs in IDLE; tick counter 0.
- Tick generator:
  - DIV = CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE), integer floor, clamped to a minimum of 1.
  - tick pulses one clk every DIV clks; free-running.
- RX input: rx passes through a 2-flop synchroniser (reset value 1); all RX logic uses the synchronised value.
- RX FSM (RX_IDLE, RX_START, RX_DATA, RX_STOP):
  - RX_IDLE: synced rx == 0 -> RX_START, tick count cleared, is_receiving=1.
  - RX_START: at OVERSAMPLE/2 ticks, sample. If 1 (glitch) -> RX_IDLE, is_receiving=0, no strobe. If 0 -> RX_DATA.
  - RX_DATA: sample every OVERSAMPLE ticks (mid-bit), shift in LSB first; after 8 bits -> RX_STOP.
  - RX_STOP: sample at mid-bit. Sample 1 -> rx_byte updated and received=1 for exactly one clk, then RX_IDLE and is_receiving=0 in the same cycle.
  - Stop sample 0 -> behaviour set by the macro. In both cases the FSM waits for synced rx==1 before re-arming RX_IDLE.
- TX FSM (TX_IDLE, TX_START, TX_DATA, TX_STOP):
  - transmit is accepted only when is_transmitting==0. Acceptance latches tx_byte, and is_transmitting=1 on the next clk edge.
  - transmit while busy is ignored: no queueing, no data corruption.
  - The new bit period starts at the first tick after acceptance.
  - tx=0 for OVERSAMPLE ticks (start), 8 data bits LSB first, OVERSAMPLE ticks each, then tx=1 for OVERSAMPLE ticks (stop).
  - is_transmitting drops the clk after the stop bit ends; a new transmit is accepted in that same low cycle.
- Full duplex: RX and TX are independent; simultaneous activity is allowed.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the partial byte is discarded, and no strobes are issued.

Optional Feature:
- Macro: UART_RECV_ERROR_EN.
- Defined:
  - Stop bit sampled 0 -> recv_error=1 for one clk; received stays 0; rx_byte keeps its previous value.
  - A byte whose RX_START sample was a glitch produces no error.
- Undefined:
  - recv_error is tied to 0.
  - Bad-stop frames are still delivered: rx_byte updated, received pulses.
  - No framing-check logic is synthesised.

Test Plan:
- Params CLOCK_FREQ=1843200, BAUD_RATE=115200, OVERSAMPLE=16 (DIV=1, 16 clk/bit) for all scenarios.
- TX frame: transmit=1 with tx_byte=0x4C ('L') -> is_transmitting=1 next clk. tx sequence 0,0,0,1,1,0,0,1,0,1, each 16 clks. is_transmitting=0 after 160 bit-clks.
- RX frame: drive 0x53 ('S') 8N1 on rx -> is_receiving=1 from start bit; received pulses exactly one clk; rx_byte=0x53, held afterward; recv_error stays 0.
- Glitch and busy-ignore:
  - rx low for 4 clks then high -> no received, no recv_error; is_receiving returns to 0 within 10 clks.
  - transmit with 0xAA mid-frame of 0x4C -> line still carries exactly 0x4C.
- Framing error: 0x41 frame with stop bit 0. With UART_RECV_ERROR_EN: recv_error one-clk pulse, received=0, rx_byte unchanged. Without: received pulses, rx_byte=0x41.
- Reset mid-frame / duplex:
  - rst=0 during data bit 3 of a TX frame -> tx=1 asynchronously, is_transmitting=0. After release, a new 0x30 frame is sent correctly.
  - Simultaneous 0x46 TX and 0x37 RX -> both complete intact.

Source files
------------

// File: rtl/uart_phy_8n1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_phy_8n1 : 8N1 UART PHY, oversampled RX/TX sharing one tick source   |
// | Optional macro: UART_RECV_ERROR_EN (stop-bit framing error strobe)       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module uart_phy_8n1 #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);

  localparam int c_DIV_RAW = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
  localparam int c_CNT_W   = $clog2(OVERSAMPLE);
  localparam logic [c_CNT_W-1:0] c_OS_LAST = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_CNT_W-1:0] c_OS_MID  = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  logic w_tick;

  generate
    if (c_DIV == 1) begin : g_tick_every_clk
      assign w_tick = 1'b1;
    end else begin : g_tick_div
      localparam int c_DIV_W = $clog2(c_DIV);
      localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(c_DIV - 1);
      localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
      logic [c_DIV_W-1:0] r_div_cnt;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                         r_div_cnt <= '0;
        else if (r_div_cnt == c_DIV_LAST) r_div_cnt <= '0;
        else                              r_div_cnt <= r_div_cnt + c_DIV_ONE;
      end
      assign w_tick = (r_div_cnt == c_DIV_LAST);
    end
  endgenerate

  logic r_rx_meta, r_rx_sync;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t          r_rx_state, w_rx_state_nxt;
  logic [c_CNT_W-1:0] r_rx_cnt,   w_rx_cnt_nxt;
  logic [2:0]         r_rx_bit,   w_rx_bit_nxt;
  logic [7:0]         r_rx_shift, w_rx_shift_nxt;
  logic [7:0]         r_rx_byte,  w_rx_byte_nxt;
  logic               r_rx_wait,  w_rx_wait_nxt;
  logic               r_received, w_received_nxt;
`ifdef UART_RECV_ERROR_EN
  logic               r_recv_error, w_recv_error_nxt;
`endif

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_byte_nxt  = r_rx_byte;
    w_rx_wait_nxt  = r_rx_wait;
    w_received_nxt = 1'b0;
`ifdef UART_RECV_ERROR_EN
    w_recv_error_nxt = 1'b0;
`endif
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (w_tick) begin
          if (r_rx_cnt == c_OS_MID) begin
            w_rx_cnt_nxt   = '0;
            w_rx_bit_nxt   = '0;
            w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + c_CNT_ONE;
          end
        end
      end
      RX_DATA: begin
        if (w_tick) begin
          if (r_rx_cnt == c_OS_LAST) begin
            w_rx_cnt_nxt   = '0;
            w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
            w_rx_bit_nxt   = r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + c_CNT_ONE;
          end
        end
      end
      RX_STOP: begin
        // After a bad stop bit, hold off re-arming until the line idles high
        if (r_rx_wait) begin
          if (r_rx_sync) begin
            w_rx_wait_nxt  = 1'b0;
            w_rx_state_nxt = RX_IDLE;
          end
        end else if (w_tick) begin
          if (r_rx_cnt == c_OS_LAST) begin
            w_rx_cnt_nxt = '0;
            if (r_rx_sync) begin
              w_rx_byte_nxt  = r_rx_shift;
              w_received_nxt = 1'b1;
              w_rx_state_nxt = RX_IDLE;
            end else begin
`ifdef UART_RECV_ERROR_EN
              w_recv_error_nxt = 1'b1;
`else
              w_rx_byte_nxt    = r_rx_shift;
              w_received_nxt   = 1'b1;
`endif
              w_rx_wait_nxt = 1'b1;
            end
          end else begin
            w_rx_cnt_nxt = r_rx_cnt + c_CNT_ONE;
          end
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_wait  <= 1'b0;
      r_received <= 1'b0;
`ifdef UART_RECV_ERROR_EN
      r_recv_error <= 1'b0;
`endif
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_byte  <= w_rx_byte_nxt;
      r_rx_wait  <= w_rx_wait_nxt;
      r_received <= w_received_nxt;
`ifdef UART_RECV_ERROR_EN
      r_recv_error <= w_recv_error_nxt;
`endif
    end
  end

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  tx_state_t          r_tx_state, w_tx_state_nxt;
  logic [c_CNT_W-1:0] r_tx_cnt,   w_tx_cnt_nxt;
  logic [2:0]         r_tx_bit,   w_tx_bit_nxt;
  logic [7:0]         r_tx_shift, w_tx_shift_nxt;
  logic               r_tx_armed, w_tx_armed_nxt;
  logic               r_tx,       w_tx_nxt;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_armed_nxt = r_tx_armed;
    w_tx_nxt       = r_tx;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_nxt = 1'b1;
        if (transmit) begin
          w_tx_state_nxt = TX_START;
          w_tx_shift_nxt = tx_byte;
          w_tx_armed_nxt = 1'b0;
        end
      end
      TX_START: begin
        // Start bit is aligned to the first tick after acceptance
        if (w_tick) begin
          if (!r_tx_armed) begin
            w_tx_armed_nxt = 1'b1;
            w_tx_nxt       = 1'b0;
            w_tx_cnt_nxt   = '0;
          end else if (r_tx_cnt == c_OS_LAST) begin
            w_tx_cnt_nxt   = '0;
            w_tx_bit_nxt   = '0;
            w_tx_nxt       = r_tx_shift[0];
            w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
            w_tx_state_nxt = TX_DATA;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + c_CNT_ONE;
          end
        end
      end
      TX_DATA: begin
        if (w_tick) begin
          if (r_tx_cnt == c_OS_LAST) begin
            w_tx_cnt_nxt = '0;
            if (r_tx_bit == 3'd7) begin
              w_tx_nxt       = 1'b1;
              w_tx_state_nxt = TX_STOP;
            end else begin
              w_tx_nxt       = r_tx_shift[0];
              w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
              w_tx_bit_nxt   = r_tx_bit + 3'd1;
            end
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + c_CNT_ONE;
          end
        end
      end
      TX_STOP: begin
        if (w_tick) begin
          if (r_tx_cnt == c_OS_LAST) begin
            w_tx_cnt_nxt   = '0;
            w_tx_state_nxt = TX_IDLE;
          end else begin
            w_tx_cnt_nxt = r_tx_cnt + c_CNT_ONE;
          end
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_armed <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_armed <= w_tx_armed_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  assign tx              = r_tx;
  assign received        = r_received;
  assign rx_byte         = r_rx_byte;
  assign is_receiving    = (r_rx_state != RX_IDLE);
  assign is_transmitting = (r_tx_state != TX_IDLE);
`ifdef UART_RECV_ERROR_EN
  assign recv_error      = r_recv_error;
`else
  assign recv_error      = 1'b0;
`endif

endmodule
`default_nettype wire
